// File: rtl/lvdc_acc_capture.sv
// Capture stage for lvdc serial accumulator telemetry: synchronises WDA/PBV/AI3V,
// frames words on PBV, delivers them via a valid/ready FIFO. Optional timeout: LVDC_ACC_TIMEOUT_EN.
module lvdc_acc_capture #(
  parameter int WORD_W      = 26,
  parameter int SKIP_BITS   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WDA,
  input  logic              PBV,
  input  logic              AI3V,
  input  logic              ACC_READY,
  input  logic              CLR_ERR,
  output logic [WORD_W-1:0] ACC_DATA,
  output logic              ACC_VALID,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic              OVF
);
  localparam int CNT_MAX = (WORD_W > SKIP_BITS) ? WORD_W : SKIP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SKIP   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // A zero skip count goes straight to data capture on frame start.
  localparam logic [1:0]       START_ST  = (SKIP_BITS == 0) ? S_SHIFT : S_SKIP;
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'((SKIP_BITS == 0) ? WORD_W : SKIP_BITS);

  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  async_in;
  logic wda_s, pbv_s, ai_s, wda_d, wda_re, pbv_prev, frame_start;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] shreg;
  logic              in_frame, timeout_hit, abort;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push_req, push, pop, full, ovf_set;

  assign async_in = {AI3V, PBV, WDA};
  assign wda_s    = sync_q[0][SYNC_STAGES-1];
  assign pbv_s    = sync_q[1][SYNC_STAGES-1];
  assign ai_s     = sync_q[2][SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      wda_d  <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      wda_d <= wda_s;
    end
  end

  assign wda_re      = wda_s & ~wda_d;
  assign frame_start = wda_re & pbv_s & ~pbv_prev;
  assign in_frame    = (state == S_SKIP) || (state == S_SHIFT);
  assign abort       = in_frame & (frame_start | timeout_hit);

`ifdef LVDC_ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge CLK) begin
    if (RST || !in_frame || wda_re) idle_cnt <= '0;
    else                            idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout_hit = in_frame && (idle_cnt == TW'(TIMEOUT_CYC));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      pbv_prev <= 1'b0;
    end else begin
      if (wda_re) pbv_prev <= pbv_s;
      case (state)
        // COMMIT lasts one cycle; a frame start landing on it chains directly.
        S_IDLE, S_COMMIT: begin
          if (frame_start) begin
            state <= START_ST;
            cnt   <= START_CNT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SKIP, S_SHIFT: begin
          if (frame_start) begin
            state <= START_ST;
            cnt   <= START_CNT;
            shreg <= '0;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            shreg <= '0;
          end else if (wda_re) begin
            cnt <= cnt - CNT_W'(1);
            if (state == S_SHIFT) shreg <= {shreg[WORD_W-2:0], ai_s};
            if (cnt == CNT_W'(1)) begin
              if (state == S_SKIP) begin
                state <= S_SHIFT;
                cnt   <= CNT_W'(WORD_W);
              end else begin
                state <= S_COMMIT;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A pop in the commit cycle frees the slot the push needs.
  assign push_req = (state == S_COMMIT);
  assign pop      = ACC_VALID & ACC_READY;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF       <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      if (ovf_set)      OVF <= 1'b1;
      else if (CLR_ERR) OVF <= 1'b0;
      if (abort)        FRAME_ERR <= 1'b1;
      else if (CLR_ERR) FRAME_ERR <= 1'b0;
    end
  end

  assign ACC_VALID = (count != '0);
  assign ACC_DATA  = ACC_VALID ? mem[rd_ptr] : '0;
  assign BUSY      = (state != S_IDLE);
endmodule

// File: tb/tb_lvdc_acc_capture.sv
// Bench for lvdc_acc_capture: word-level queue model of the output FIFO checked every cycle,
// plus directed frames with literal expectations.
module tb_lvdc_acc_capture;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0, RST = 1'b1, WDA = 1'b0, PBV = 1'b0, AI3V = 1'b0;
  logic        ACC_READY = 1'b0, CLR_ERR = 1'b0;
  logic [25:0] ACC_DATA;
  logic        ACC_VALID, BUSY, FRAME_ERR, OVF;

  int errs = 0, checks = 0, cyc = 0;
  logic [25:0] mq[$];
  logic [25:0] pw[$];
  int          pt[$];
  bit          ovf_exp = 1'b0, ferr_exp = 1'b0;

  always #5 CLK = ~CLK;

  lvdc_acc_capture dut (
    .CLK(CLK), .RST(RST), .WDA(WDA), .PBV(PBV), .AI3V(AI3V),
    .ACC_READY(ACC_READY), .CLR_ERR(CLR_ERR),
    .ACC_DATA(ACC_DATA), .ACC_VALID(ACC_VALID), .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR), .OVF(OVF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  // Model: a completed word is offered to the FIFO 4 cycles after its last WDA rise is driven
  // (2 sync flops, edge detect, one commit cycle); it is dropped if the queue is full.
  initial forever begin
    @(posedge CLK);
    cyc++;
    #1;
    while (pt.size() != 0 && pt[0] <= cyc) begin
      if (mq.size() < DEPTH) mq.push_back(pw[0]);
      else                   ovf_exp = 1'b1;
      void'(pw.pop_front());
      void'(pt.pop_front());
    end
  end

  // Per-cycle compare of the output handshake against the model queue.
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      chk("acc_valid", ACC_VALID, mq.size() != 0);
      if (ACC_VALID && ACC_READY && mq.size() != 0) begin
        chk("acc_data", ACC_DATA, mq[0]);
        void'(mq.pop_front());
      end
    end
  end

  task automatic wda_edge(input logic b, input logic p);
    repeat (2) @(posedge CLK);
    #1 WDA = 1'b0; AI3V = b;
    repeat (2) @(posedge CLK);
    #1 WDA = 1'b1; PBV = p;
  endtask

  task automatic send_frame(input logic [25:0] w, input int nbits);
    wda_edge(1'b0, 1'b1);
    wda_edge(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) wda_edge(w[25-i], 1'b0);
    if (nbits == 26) begin
      pw.push_back(w);
      pt.push_back(cyc + 4);
    end
  endtask

  task automatic pop_one();
    @(posedge CLK); #1 ACC_READY = 1'b1;
    @(posedge CLK); #1 ACC_READY = 1'b0;
  endtask

  task automatic clr_err();
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    ovf_exp = 1'b0; ferr_exp = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, ACC_VALID, 0);
    chk({tag, "_data"},  ACC_DATA, 0);
    chk({tag, "_busy"},  BUSY, 0);
    chk({tag, "_ferr"},  FRAME_ERR, 0);
    chk({tag, "_ovf"},   OVF, 0);
  endtask

  initial begin
    settle(3);
    chk_all_zero("reset");
    @(posedge CLK); #1 RST = 1'b0;

    // Single frame with latency pin
    send_frame(26'h2AAAAAA, 26);
    settle(3);
    chk("lat_before", ACC_VALID, 0);
    settle(1);
    chk("lat_at", ACC_VALID, 1);
    chk("t1_data", ACC_DATA, 26'h2AAAAAA);
    chk("t1_busy", BUSY, 0);
    pop_one();
    settle(2);
    chk("t1_empty", ACC_VALID, 0);

    // Back-to-back frames held, third overflows
    send_frame(26'h0000001, 26);
    send_frame(26'h3FFFFFF, 26);
    settle(6);
    chk("b2b_head", ACC_DATA, 26'h0000001);
    chk("b2b_no_ovf", OVF, 0);
    send_frame(26'h1555555, 26);
    settle(6);
    chk("ovf_lit", OVF, 1);
    chk("ovf_model", OVF, ovf_exp);
    chk("ovf_head", ACC_DATA, 26'h0000001);
    pop_one();
    settle(0);
    chk("ovf_second", ACC_DATA, 26'h3FFFFFF);
    pop_one();
    clr_err();
    settle(0);
    chk("ovf_clr", OVF, 0);
    chk("ovf_empty", ACC_VALID, 0);

    // PBV restart mid-frame, then an intact frame
    send_frame(26'h0FEDCBA, 10);
    ferr_exp = 1'b1;
    send_frame(26'h1234567, 26);
    settle(6);
    chk("ferr_lit", FRAME_ERR, 1);
    chk("ferr_model", FRAME_ERR, ferr_exp);
    chk("restart_data", ACC_DATA, 26'h1234567);
    pop_one();
    clr_err();
    settle(0);
    chk("ferr_clr", FRAME_ERR, 0);

    // Full FIFO, pop coinciding with the commit cycle
    send_frame(26'h0ABCDEF, 26);
    send_frame(26'h1357913, 26);
    send_frame(26'h2468ACE, 26);
    repeat (3) @(posedge CLK);
    #1 ACC_READY = 1'b1;
    @(posedge CLK); #1 ACC_READY = 1'b0;
    settle(4);
    chk("full_pop_ovf", OVF, 0);
    chk("full_pop_head", ACC_DATA, 26'h1357913);
    pop_one();
    settle(0);
    chk("full_pop_tail", ACC_DATA, 26'h2468ACE);
    pop_one();

    // Reset in the middle of a frame with a word buffered
    send_frame(26'h0AAAAAA, 26);
    settle(6);
    send_frame(26'h3FFFFFF, 13);
    settle(4);
    chk("mid_busy", BUSY, 1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 mq.delete(); pw.delete(); pt.delete();
    @(negedge CLK);
    chk_all_zero("mid_rst");
    @(posedge CLK); #1 RST = 1'b0; PBV = 1'b0;
    send_frame(26'h0F0F0F0, 26);
    settle(6);
    chk("post_rst_data", ACC_DATA, 26'h0F0F0F0);
    chk("post_rst_ferr", FRAME_ERR, 0);
    pop_one();

    // WDA stalls mid-frame
    send_frame(26'h3FFFFFF, 5);
    settle(4110);
`ifdef LVDC_ACC_TIMEOUT_EN
    chk("tmo_ferr", FRAME_ERR, 1);
    chk("tmo_busy", BUSY, 0);
`else
    chk("stall_busy", BUSY, 1);
    chk("stall_ferr", FRAME_ERR, 0);
`endif
    @(posedge CLK); #1 RST = 1'b1;
    settle(1);
    #1 RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
